rx_fifo_param: RTL
==================

// Module: rx_fifo_param
// PURPOSE
//  Parametrised receive FIFO between SSP receive logic and the APB-style processor port.
//  Buffers deserialised words from the SSP side and presents the oldest word on PRDATA.
//  Adds programmable depth/width, a level-threshold interrupt, a sticky overrun flag and
//  an optional receive-timeout interrupt.
// PARAMETERS
//  DATA_WIDTH   8   width of each word (RxData, PRDATA)
//  DEPTH        4   entries; power of two, >= 2
//  RX_THRESH    4   SSPRXINTR level; legal range 1..DEPTH
//  TIMEOUT_CYC  32  idle cycles before timeout interrupt; >= 1 (used only with RX_TIMEOUT_EN)
// PORTS
//  PCLK        in   1                    clock; all logic on rising edge
//  CLEAR       in   1                    synchronous, active-high reset
//  PSEL        in   1                    processor select
//  PWRITE      in   1                    1 = write, 0 = read; pop only when PSEL & ~PWRITE
//  RxData      in   DATA_WIDTH           word from SSP receive logic
//  NextWord    in   1                    push strobe, one word per high cycle
//  PRDATA      out  DATA_WIDTH           head (oldest) word; 0 when empty
//  SSPRXINTR   out  1                    level interrupt: RXCOUNT >= RX_THRESH
//  SSPRXTOINTR out  1                    receive-timeout interrupt
//  SSPRXOVR    out  1                    sticky overrun flag
//  RXCOUNT     out  $clog2(DEPTH+1)      entries held
//  RXEMPTY     out  1                    RXCOUNT == 0
//  RXFULL      out  1                    RXCOUNT == DEPTH
// BEHAVIOUR
//  Reset: CLEAR=1 at a PCLK edge -> pointers 0, RXCOUNT 0, SSPRXOVR 0, timeout counter 0,
//   SSPRXTOINTR 0. Outputs then: PRDATA 0, RXEMPTY 1, RXFULL 0, SSPRXINTR 0. Memory not cleared.
//   CLEAR wins over push/pop in the same cycle; in-flight data is discarded.
//  Push: NextWord=1 & ~RXFULL -> RxData written at wr_ptr, wr_ptr+1 (wraps mod DEPTH).
//  Overrun: NextWord=1 & RXFULL & ~pop -> word dropped, contents unchanged, SSPRXOVR <= 1;
//   SSPRXOVR holds until CLEAR.
//  Pop: PSEL=1 & PWRITE=0 & ~RXEMPTY -> rd_ptr+1 (wraps). Each cycle with PSEL & ~PWRITE
//   high is one pop. Pop on empty is ignored, no flag.
//  PRDATA: show-ahead, combinational from mem[rd_ptr] gated by ~RXEMPTY. Processor samples
//   PRDATA in the pop cycle; the next word appears the following cycle.
//  Simultaneous push+pop: full -> both occur, RXCOUNT stays DEPTH, no overrun.
//   empty -> push only, RXCOUNT 1. Otherwise both occur, RXCOUNT unchanged.
//  RXCOUNT: registered, +1 push-only, -1 pop-only, never exceeds DEPTH or wraps below 0.
//  SSPRXINTR, RXEMPTY, RXFULL: combinational from registered RXCOUNT; they change on the edge
//   after the causing push/pop.
//  Write-path latency: word pushed at edge N is visible on PRDATA after edge N if the FIFO
//   was empty.
// CONFIGURATION
//  RX_TIMEOUT_EN defined: timeout counter (width $clog2(TIMEOUT_CYC+1)).
//   Counter clears to 0 on any accepted push, any accepted pop, or RXEMPTY.
//   Otherwise the counter increments per cycle, saturating at TIMEOUT_CYC.
//   SSPRXTOINTR = (counter == TIMEOUT_CYC) & ~RXEMPTY & ~SSPRXINTR.
//   SSPRXTOINTR drops the cycle after the next push/pop, or on CLEAR.
//  RX_TIMEOUT_EN undefined: no counter; SSPRXTOINTR tied 0. Port list identical either way.
// TESTING
//  T1 reset: CLEAR 1 cycle mid-traffic -> RXCOUNT 0, RXEMPTY 1, PRDATA 0, SSPRXOVR 0
//   on the next cycle.
//  T2 order/wrap (DEPTH 4): push 0x11..0x44, pop 4, push 0x55,0x66, pop 2
//   -> PRDATA seq 11,22,33,44,55,66; RXEMPTY 1 at end.
//  T3 threshold (RX_THRESH 3): push 3 words -> SSPRXINTR 1 the edge after 3rd push;
//   one pop -> 0 next edge.
//  T4 overrun: fill 4, push 0xAA -> SSPRXOVR 1, contents unchanged, RXCOUNT 4; pop all
//   -> SSPRXOVR still 1 until CLEAR.
//  T5 simultaneous: full + push 0x77 & pop same cycle -> RXCOUNT 4, no overrun, 0x77 last out;
//   empty + push & pop -> RXCOUNT 1.
//  T6 timeout (RX_TIMEOUT_EN, TIMEOUT_CYC 8, RX_THRESH 4): push 1 word, idle
//   -> SSPRXTOINTR 1 after 8 idle cycles; pop -> 0 next edge; build without macro -> always 0.

Source files
------------

// File: rtl/rx_fifo_param.sv
// rtl/rx_fifo_param.sv - parametrised SSP receive FIFO with level, overrun and timeout status
//
// Buffers words from the SSP receive deserialiser and presents the oldest one
// on PRDATA (show-ahead) to the processor read port.
//
// Optional feature macro: RX_TIMEOUT_EN (adds the receive-timeout counter; the
// port list is the same whether or not it is defined).
//
// Ports:
//   PCLK        in   clock, all state updates on the rising edge
//   CLEAR       in   synchronous active-high reset
//   PSEL        in   processor select
//   PWRITE      in   1 = write, 0 = read; each PSEL & ~PWRITE cycle is one pop
//   RxData      in   word from the SSP receive logic
//   NextWord    in   push strobe, one word per high cycle
//   PRDATA      out  oldest word, 0 when empty
//   SSPRXINTR   out  level interrupt, RXCOUNT >= RX_THRESH
//   SSPRXTOINTR out  receive-timeout interrupt (0 without RX_TIMEOUT_EN)
//   SSPRXOVR    out  sticky overrun flag, cleared only by CLEAR
//   RXCOUNT     out  number of entries held
//   RXEMPTY     out  RXCOUNT == 0
//   RXFULL      out  RXCOUNT == DEPTH

module rx_fifo_param #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int RX_THRESH   = 4,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                         PCLK,
    input  logic                         CLEAR,
    input  logic                         PSEL,
    input  logic                         PWRITE,
    input  logic [DATA_WIDTH-1:0]        RxData,
    input  logic                         NextWord,
    output logic [DATA_WIDTH-1:0]        PRDATA,
    output logic                         SSPRXINTR,
    output logic                         SSPRXTOINTR,
    output logic                         SSPRXOVR,
    output logic [$clog2(DEPTH+1)-1:0]   RXCOUNT,
    output logic                         RXEMPTY,
    output logic                         RXFULL
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(RX_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  ovr;

    logic pop_req;
    logic pop_ok;
    logic push_ok;

    assign RXCOUNT   = count;
    assign RXEMPTY   = (count == '0);
    assign RXFULL    = (count == DEPTH_C);
    assign SSPRXINTR = (count >= THRESH_C);
    assign SSPRXOVR  = ovr;

    // A full FIFO still accepts a push when the same cycle pops, since a slot
    // frees up at the same edge; only push-while-full-without-pop is an overrun.
    assign pop_req = PSEL & ~PWRITE;
    assign pop_ok  = pop_req & ~RXEMPTY;
    assign push_ok = NextWord & (~RXFULL | pop_ok);

    assign PRDATA = RXEMPTY ? '0 : mem[rd_ptr];

    // Storage is deliberately not reset; PRDATA is gated by RXEMPTY instead.
    always_ff @(posedge PCLK) begin
        if (!CLEAR && push_ok) begin
            mem[wr_ptr] <= RxData;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (NextWord && RXFULL && !pop_req) begin
                ovr <= 1'b1;
            end
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

    logic [TW-1:0] tmo_cnt;

    // Counts idle cycles while data sits unread; any FIFO activity or an
    // empty FIFO restarts it, and it saturates so the interrupt stays up.
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            tmo_cnt <= '0;
        end else if (push_ok || pop_ok || RXEMPTY) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Suppressed while the level interrupt is up; that one already demands service.
    assign SSPRXTOINTR = (tmo_cnt == TMO_MAX) & ~RXEMPTY & ~SSPRXINTR;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYC > 0);
    assign SSPRXTOINTR    = 1'b0;
`endif

endmodule
